// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC ownership, single-outstanding imem fetch, decode register
// Redirects from decode squash the sequential successor; there is no branch delay slot.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] EXC_PC    = 32'h0000_0080,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic [2:0]  if_PCSrcSel,
  input  logic [31:0] if_RFOutA,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] if_instr,
  output logic [31:0] if_PC,
  output logic        if_valid
);

  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] fetch_pc, fetch_pc_nxt;
  logic [31:0] redirect_pc, redirect_pc_nxt;
  logic [31:0] hold_buf, hold_buf_nxt;
  logic [31:0] hold_pc, hold_pc_nxt;
  logic        kill, kill_nxt;

  logic [31:0] if_instr_nxt, if_PC_nxt;
  logic        if_valid_nxt;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc4;
  logic [31:0] br_off;

  logic        accept;
  logic [31:0] acc_instr;
  logic [31:0] acc_pc;

  // Redirect target is derived from the instruction currently held in the decode register.
  always_comb begin
    pc4    = if_PC + 32'd4;
    br_off = {{14{if_instr[15]}}, if_instr[15:0], 2'b00};
    target = pc4;
    casez (if_PCSrcSel)
      3'b001:  target = pc4 + br_off;
      3'b010:  target = {pc4[31:28], if_instr[25:0], 2'b00};
      3'b011:  target = if_RFOutA & ~32'd3;
      3'b1??:  target = EXC_PC;
      default: target = pc4;
    endcase
  end

  assign redirect  = (if_PCSrcSel != 3'b000) && !stall;
  assign imem_addr = {fetch_pc[31:2], 2'b00};

  always_comb begin
    state_nxt       = state;
    fetch_pc_nxt    = fetch_pc;
    redirect_pc_nxt = redirect_pc;
    hold_buf_nxt    = hold_buf;
    hold_pc_nxt     = hold_pc;
    kill_nxt        = kill;
    imem_req        = 1'b0;
    accept          = 1'b0;
    acc_instr       = imem_rdata;
    acc_pc          = fetch_pc;

    case (state)
      S_RST: begin
        state_nxt = S_REQ;
      end

      S_REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (kill || redirect) begin
            // The returning word belongs to a squashed path.
            fetch_pc_nxt = redirect ? target : redirect_pc;
            kill_nxt     = 1'b0;
          end else if (!stall) begin
            accept       = 1'b1;
            fetch_pc_nxt = fetch_pc + 32'd4;
          end else begin
            hold_buf_nxt = imem_rdata;
            hold_pc_nxt  = fetch_pc;
            state_nxt    = S_HOLD;
          end
        end else if (redirect) begin
          // Keep the address stable until ack; remember the newest target.
          kill_nxt        = 1'b1;
          redirect_pc_nxt = target;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          fetch_pc_nxt = target;
          state_nxt    = S_REQ;
        end else if (!stall) begin
          accept       = 1'b1;
          acc_instr    = hold_buf;
          acc_pc       = hold_pc;
          fetch_pc_nxt = hold_pc + 32'd4;
          state_nxt    = S_REQ;
        end
      end

      default: begin
        state_nxt = S_RST;
      end
    endcase
  end

  always_comb begin
    if_instr_nxt = if_instr;
    if_PC_nxt    = if_PC;
    if_valid_nxt = if_valid;
    if (stall) begin
      if_instr_nxt = if_instr;
    end else if (redirect) begin
      if_instr_nxt = NOP_INSTR;
      if_valid_nxt = 1'b0;
    end else if (accept) begin
      if_instr_nxt = acc_instr;
      if_PC_nxt    = acc_pc;
      if_valid_nxt = 1'b1;
    end else begin
      if_instr_nxt = NOP_INSTR;
      if_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= S_RST;
      fetch_pc    <= RESET_PC;
      redirect_pc <= 32'd0;
      hold_buf    <= 32'd0;
      hold_pc     <= 32'd0;
      kill        <= 1'b0;
      if_instr    <= NOP_INSTR;
      if_PC       <= 32'd0;
      if_valid    <= 1'b0;
    end else begin
      state       <= state_nxt;
      fetch_pc    <= fetch_pc_nxt;
      redirect_pc <= redirect_pc_nxt;
      hold_buf    <= hold_buf_nxt;
      hold_pc     <= hold_pc_nxt;
      kill        <= kill_nxt;
      if_instr    <= if_instr_nxt;
      if_PC       <= if_PC_nxt;
      if_valid    <= if_valid_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage with a transaction-level stream model
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] EXC_PC    = 32'h0000_0080;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  logic        clock;
  logic        reset;
  logic        stall;
  logic [2:0]  if_PCSrcSel;
  logic [31:0] if_RFOutA;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] if_instr;
  logic [31:0] if_PC;
  logic        if_valid;

  fetch_stage #(
    .RESET_PC  (RESET_PC),
    .EXC_PC    (EXC_PC),
    .NOP_INSTR (NOP_INSTR)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .stall       (stall),
    .if_PCSrcSel (if_PCSrcSel),
    .if_RFOutA   (if_RFOutA),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .if_instr    (if_instr),
    .if_PC       (if_PC),
    .if_valid    (if_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_miss = 0;
  int n_deliv = 0;

  // Stream-level model: what decode should see, which address must be on the bus,
  // whether an in-flight word is doomed, and whether an acked word is parked.
  logic        m_first, m_held, m_discard, m_waiting, m_valid;
  logic [31:0] m_next_pc, m_held_pc, m_wait_addr, m_pc, m_instr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0000_0020) ? 32'h1000_FFFE : a;
  endfunction

  function automatic logic [31:0] redirect_target(input logic [2:0] sel, input logic [31:0] rfa,
                                                  input logic [31:0] pc, input logic [31:0] ins);
    logic [31:0] seq;
    logic [31:0] off;
    seq = pc + 32'd4;
    off = {{14{ins[15]}}, ins[15:0], 2'b00};
    if (sel[2])             return EXC_PC;
    else if (sel == 3'b001) return seq + off;
    else if (sel == 3'b010) return {seq[31:28], ins[25:0], 2'b00};
    else                    return {rfa[31:2], 2'b00};
  endfunction

  task automatic model_reset();
    m_first   = 1'b1;
    m_held    = 1'b0;
    m_discard = 1'b0;
    m_waiting = 1'b0;
    m_valid   = 1'b0;
    m_next_pc = RESET_PC;
    m_held_pc = 32'd0;
    m_wait_addr = 32'd0;
    m_pc      = 32'd0;
    m_instr   = NOP_INSTR;
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    stall       = 1'b0;
    if_PCSrcSel = 3'b000;
    if_RFOutA   = 32'd0;
    imem_ack    = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(posedge clock);
    #1;
    chk("rst_if_instr", if_instr, NOP_INSTR);
    chk("rst_if_PC", if_PC, 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic step(input logic st, input logic [2:0] sel_in, input logic [31:0] rfa, input logic ak);
    logic [2:0]  sel;
    logic        red, rq, dlv;
    logic [31:0] tgt, ad, dpc;
    sel = m_first ? 3'b000 : sel_in;
    stall       = st;
    if_PCSrcSel = sel;
    if_RFOutA   = rfa;
    imem_ack    = ak;
    imem_rdata  = mem_word(imem_addr);
    rq = imem_req;
    ad = imem_addr;
    chk("imem_req", 32'(rq), 32'(!m_held && !m_first));
    if (m_waiting) chk("addr_stable", ad, m_wait_addr);
    if (rq && !m_discard) chk("imem_addr", ad, m_next_pc);
    red = (sel != 3'b000) && !st;
    tgt = redirect_target(sel, rfa, m_pc, m_instr);

    @(posedge clock);
    #1;

    dlv = 1'b0;
    dpc = m_next_pc;
    if (m_held) begin
      if (red) m_held = 1'b0;
      else if (!st) begin
        dlv = 1'b1;
        dpc = m_held_pc;
        m_held = 1'b0;
      end
    end else if (rq && ak) begin
      if (m_discard || red) m_discard = 1'b0;
      else if (st) begin
        m_held    = 1'b1;
        m_held_pc = m_next_pc;
      end else dlv = 1'b1;
    end else if (rq && red) begin
      m_discard = 1'b1;
    end
    m_waiting   = rq && !ak;
    m_wait_addr = ad;

    if (!st) begin
      if (!red && dlv) begin
        m_valid   = 1'b1;
        m_pc      = dpc;
        m_instr   = mem_word(dpc);
        m_next_pc = dpc + 32'd4;
        n_deliv++;
      end else begin
        m_valid = 1'b0;
        m_instr = NOP_INSTR;
      end
    end
    if (red) m_next_pc = tgt;
    m_first = 1'b0;

    chk("if_valid", 32'(if_valid), 32'(m_valid));
    chk("if_PC", if_PC, m_pc);
    chk("if_instr", if_instr, m_instr);
  endtask

  initial begin
    reset       = 1'b0;
    stall       = 1'b0;
    if_PCSrcSel = 3'b000;
    if_RFOutA   = 32'd0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'd0;
    model_reset();
    do_reset();

    // Zero-wait sequential fetch, then a 3-cycle wait at 0x8.
    step(0, 3'b000, 0, 1);
    step(0, 3'b000, 0, 1);
    chk("seq_pc0", if_PC, 32'h0);
    step(0, 3'b000, 0, 1);
    chk("seq_pc4", if_PC, 32'h4);
    for (int i = 0; i < 3; i++) step(0, 3'b000, 0, 0);
    step(0, 3'b000, 0, 1);
    chk("wait_pc8", if_PC, 32'h8);

    // Stall while the word at 0x10 is acked.
    step(0, 3'b000, 0, 1);
    step(1, 3'b000, 0, 1);
    step(1, 3'b000, 0, 0);
    chk("hold_req", 32'(imem_req), 32'd0);
    step(0, 3'b000, 0, 0);
    chk("hold_pc10", if_PC, 32'h10);
    chk("hold_next", imem_addr, 32'h14);
    for (int i = 0; i < 4; i++) step(0, 3'b000, 0, 1);
    chk("beq_at20", if_instr, 32'h1000_FFFE);

    // Backward branch squashes the word fetched at 0x24.
    step(0, 3'b001, 0, 1);
    chk("br_squash", 32'(if_valid), 32'd0);
    chk("br_target", imem_addr, 32'h1C);

    // jr while a request is pending, then a second jr with a delayed ack.
    step(0, 3'b011, 32'h40, 0);
    step(0, 3'b000, 0, 1);
    step(0, 3'b011, 32'h1003, 0);
    step(0, 3'b000, 0, 0);
    step(0, 3'b000, 0, 1);
    chk("jr_target", imem_addr, 32'h1000);

    // Exception select ignored under stall, then taken.
    step(1, 3'b100, 0, 0);
    step(1, 3'b100, 0, 0);
    step(0, 3'b100, 0, 1);
    chk("exc_target", imem_addr, EXC_PC);

    // Reset while a request is waiting.
    step(0, 3'b000, 0, 0);
    do_reset();

    // Fetch address wraps past the top of memory.
    step(0, 3'b000, 0, 1);
    step(0, 3'b000, 0, 1);
    step(0, 3'b011, 32'hFFFF_FFFF, 1);
    step(0, 3'b000, 0, 1);
    chk("wrap_pc", if_PC, 32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr, 32'h0);

    n_deliv = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 99) < 25),
             ($urandom_range(0, 99) < 15) ? 3'($urandom_range(1, 7)) : 3'b000,
             $urandom,
             ($urandom_range(0, 99) < 60));
      end
    end
    chk("progress", 32'(n_deliv > 300), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
